uart_rx_framer: RTL

//  UART receive framer: consumes the debounced RX line produced by the input filter stage and
//  the 16x-baud enable. Detects start bits, samples data/parity/stop at bit centre and

---
 rtl/uart_rx_framer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_framer.sv
// UART receive framer: start detect, mid-bit sampling, LSB-first deserialise, PE/FE/BI status.
// Optional build macro UART_RX_MAJORITY_EN: 3-sample majority vote per bit, decisions one tick later.
module uart_rx_framer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       RXD,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  output logic [7:0] DOUT,
  output logic       PE,
  output logic       FE,
  output logic       BI,
  output logic       RXFINISHED
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] S_PT = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] DEC = TW'(OVERSAMPLE / 2);
`else
  localparam logic [TW-1:0] DEC = S_PT;
`endif

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] MWAIT = 3'd5;

  logic [2:0]    state;
  logic [TW-1:0] tick;
  logic [2:0]    bitcnt;
  logic [2:0]    len_m1;
  logic          pen_q, eps_q, sp_q;
  logic [7:0]    shadow;
  logic          pbit;
  logic          sample;
  logic          pe_calc;
  logic          bi_calc;

`ifdef UART_RX_MAJORITY_EN
  logic m0, m1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      m0 <= 1'b1;
      m1 <= 1'b1;
    end else if (CE) begin
      if (tick == S_PT - 1'b1) m0 <= RXD;
      if (tick == S_PT)        m1 <= RXD;
    end
  end

  assign sample = (m0 & m1) | (m0 & RXD) | (m1 & RXD);
`else
  assign sample = RXD;
`endif

  // Stick parity: the parity bit itself must equal ~EPS.
  always_comb begin
    pe_calc = 1'b0;
    if (pen_q) begin
      if (sp_q) pe_calc = (pbit == eps_q);
      else      pe_calc = ((^shadow) ^ pbit) == eps_q;
    end
    bi_calc = (shadow == 8'h00) && !pbit && !sample;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      tick       <= '0;
      bitcnt     <= '0;
      len_m1     <= '0;
      pen_q      <= 1'b0;
      eps_q      <= 1'b0;
      sp_q       <= 1'b0;
      shadow     <= '0;
      pbit       <= 1'b0;
      DOUT       <= '0;
      PE         <= 1'b0;
      FE         <= 1'b0;
      BI         <= 1'b0;
      RXFINISHED <= 1'b0;
    end else begin
      RXFINISHED <= 1'b0;
      if (CE) begin
        tick <= tick + 1'b1;
        case (state)
          IDLE: begin
            // The CE that sees the falling edge is tick 0 of the start bit.
            tick <= '0;
            if (!RXD) begin
              state  <= START;
              tick   <= TW'(1);
              len_m1 <= {1'b1, WLS};
              pen_q  <= PEN;
              eps_q  <= EPS;
              sp_q   <= SP;
              shadow <= '0;
              pbit   <= 1'b0;
              bitcnt <= '0;
            end
          end
          START: begin
            if (tick == DEC && sample) begin
              state <= IDLE;
              tick  <= '0;
            end else if (tick == LAST) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            if (tick == DEC) shadow[bitcnt] <= sample;
            if (tick == LAST) begin
              if (bitcnt == len_m1) state <= pen_q ? PAR : STOP;
              else                  bitcnt <= bitcnt + 3'd1;
            end
          end
          PAR: begin
            if (tick == DEC)  pbit  <= sample;
            if (tick == LAST) state <= STOP;
          end
          STOP: begin
            if (tick == DEC) begin
              DOUT       <= shadow;
              PE         <= pe_calc;
              FE         <= !sample;
              BI         <= bi_calc;
              RXFINISHED <= 1'b1;
              state      <= sample ? IDLE : MWAIT;
              tick       <= '0;
            end
          end
          MWAIT: begin
            tick <= '0;
            if (RXD) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
